spatial_array_accum_ctrl: RTL and testbench

Per-column accumulation sequencer for the 8x8 spatial array's south-edge accumulators. It accepts a job command (beat count and column mask), clears the selected column accumulators, and gates each column's accumulate-enable on that column's valid beats until the requested count is reached. It then waits out the accumulator pipeline and reports completion through a valid/ready handshake. It sits between the array-level scheduler and the `rst_accumulator` / `enable_accumulator` / `south_data_out_valid` ports of the spatial array.

---
 rtl/spatial_array_accum_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_spatial_array_accum_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spatial_array_accum_ctrl.sv
// Per-column accumulate sequencer: clear, gate enables until count, drain, report done (ACCUM_CTRL_TIMEOUT_EN adds a watchdog).
// Latency: CLEAR one cycle after accept, done DRAIN_CYCLES+1 cycles after the last required beat.
// Backpressure: cmd_ready only in IDLE; done_valid/done_col_mask hold until done_ready.
module spatial_array_accum_ctrl #(
  parameter int NUM_COLS       = 8,
  parameter int COUNT_WIDTH    = 8,
  parameter int DRAIN_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [COUNT_WIDTH-1:0] cmd_count,
  input  logic [NUM_COLS-1:0]    cmd_col_mask,
  input  logic                   col_data_valid     [0:NUM_COLS-1],
  output logic                   rst_accumulator    [0:NUM_COLS-1],
  output logic                   enable_accumulator [0:NUM_COLS-1],
  output logic                   busy,
  output logic                   done_valid,
  input  logic                   done_ready,
  output logic [NUM_COLS-1:0]    done_col_mask,
  output logic                   overflow,
  output logic                   timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_DONE} state_t;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]  count_q;
  logic [NUM_COLS-1:0]     mask_q, done_mask_q;
  logic [COUNT_WIDTH-1:0]  cnt_q [NUM_COLS];
  logic                    overflow_q;
  logic [DW-1:0]           drain_q;

  logic [NUM_COLS-1:0]     vld_vec, en_vec, clr_vec, drop_vec, reach_now, reach_next;
  logic                    accept, drain_last, wd_fire;

  // Per-column gating; reach_next folds in this cycle's beat so DRAIN starts right after the last one.
  always_comb begin
    vld_vec    = '0;
    en_vec     = '0;
    clr_vec    = '0;
    drop_vec   = '0;
    reach_now  = '0;
    reach_next = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      vld_vec[c]    = col_data_valid[c];
      reach_now[c]  = (cnt_q[c] == count_q);
      en_vec[c]     = !rst && (state_q == S_ACCUM) && vld_vec[c] && mask_q[c] && !reach_now[c];
      reach_next[c] = !mask_q[c] || reach_now[c] ||
                      (en_vec[c] && ((cnt_q[c] + COUNT_WIDTH'(1)) == count_q));
      drop_vec[c]   = vld_vec[c] && mask_q[c] &&
                      ((state_q == S_CLEAR) || ((state_q == S_ACCUM) && reach_now[c]));
      clr_vec[c]    = (state_q == S_CLEAR) && mask_q[c];
    end
  end

  assign drain_last = (drain_q == DW'(DRAIN_CYCLES - 1));

`ifdef ACCUM_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_q;
  logic          timeout_q;

  assign wd_fire = (state_q == S_ACCUM) && !(&reach_next) && (en_vec == '0) &&
                   (wd_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q <= ((state_q == S_ACCUM) && (en_vec == '0)) ? wd_q + TW'(1) : '0;
      if (accept)
        timeout_q <= 1'b0;
      else if (wd_fire)
        timeout_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_q && !rst;
`else
  assign wd_fire     = 1'b0;
  // TIMEOUT_CYCLES only matters with the watchdog; this is constant 0 for any legal value.
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done_valid = 1'b0;
    accept     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) begin
          accept  = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy    = !rst;
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        busy = !rst;
        if (&reach_next)
          state_d = S_DRAIN;
        else if (wd_fire)
          state_d = S_DONE;
      end
      S_DRAIN: begin
        busy = !rst;
        if (drain_last)
          state_d = S_DONE;
      end
      S_DONE: begin
        busy       = !rst;
        done_valid = !rst;
        if (done_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      mask_q      <= '0;
      done_mask_q <= '0;
      overflow_q  <= 1'b0;
      drain_q     <= '0;
      for (int c = 0; c < NUM_COLS; c++)
        cnt_q[c] <= '0;
    end else begin
      drain_q <= (state_q == S_DRAIN) ? drain_q + DW'(1) : '0;
      if (accept) begin
        count_q     <= cmd_count;
        mask_q      <= cmd_col_mask;
        done_mask_q <= cmd_col_mask;
        overflow_q  <= 1'b0;
        for (int c = 0; c < NUM_COLS; c++)
          cnt_q[c] <= '0;
      end else begin
        for (int c = 0; c < NUM_COLS; c++)
          if (en_vec[c])
            cnt_q[c] <= cnt_q[c] + COUNT_WIDTH'(1);
        if (|drop_vec)
          overflow_q <= 1'b1;
        // A watchdog stop reports only the columns that actually completed.
        if (wd_fire)
          done_mask_q <= mask_q & reach_now;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_COLS; c++) begin
      rst_accumulator[c]    = rst || clr_vec[c];
      enable_accumulator[c] = en_vec[c];
    end
  end

  assign done_col_mask = done_valid ? done_mask_q : '0;
  assign overflow      = overflow_q && !rst;

endmodule

// File: tb/tb_spatial_array_accum_ctrl.sv
// Directed table-driven bench for spatial_array_accum_ctrl plus hand-written multi-cycle sequences.
module tb_spatial_array_accum_ctrl;
  localparam int NC = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cmd_valid, cmd_ready, done_ready, busy, done_valid, overflow, timeout_err;
  logic [CW-1:0] cmd_count;
  logic [NC-1:0] cmd_col_mask, done_col_mask;
  logic          col_data_valid     [0:NC-1];
  logic          rst_accumulator    [0:NC-1];
  logic          enable_accumulator [0:NC-1];
  logic [NC-1:0] vld_p, clr_p, en_p;

  always_comb begin
    clr_p = '0;
    en_p  = '0;
    for (int c = 0; c < NC; c++) begin
      col_data_valid[c] = vld_p[c];
      clr_p[c]          = rst_accumulator[c];
      en_p[c]           = enable_accumulator[c];
    end
  end

  spatial_array_accum_ctrl #(.NUM_COLS(NC), .COUNT_WIDTH(CW), .DRAIN_CYCLES(1), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_count(cmd_count),
    .cmd_col_mask(cmd_col_mask), .col_data_valid(col_data_valid), .rst_accumulator(rst_accumulator),
    .enable_accumulator(enable_accumulator), .busy(busy), .done_valid(done_valid),
    .done_ready(done_ready), .done_col_mask(done_col_mask), .overflow(overflow),
    .timeout_err(timeout_err));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] count;
    logic [7:0] mask;
    logic [7:0] vld;
    int         vstart;
    int         vlen;
    int         exp_en;
    int         exp_done;
    logic       exp_ovf;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] pat  [0:15];
  int         done_at, en_total, clr_other;
  int         en_col [NC];
  logic [7:0] clr_at1;
  logic       ovf_at1;

  // Accept a job in cycle 0, then drive valids per cycle k until done_valid or the budget runs out.
  task automatic run_job(input logic [7:0] cnt, input logic [7:0] mask, input logic [7:0] vld,
                         input int vstart, input int vlen, input bit upat, input string tag);
    done_at   = -1;
    en_total  = 0;
    clr_other = 0;
    for (int c = 0; c < NC; c++) en_col[c] = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_count = cnt; cmd_col_mask = mask; vld_p = '0;
    @(negedge clk);
    check({tag, " accept_ready"}, 32'(cmd_ready), 32'd1);
    for (int k = 1; k < 400; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (upat) vld_p = (k < 16) ? pat[k] : '0;
      else      vld_p = (k >= vstart && k < vstart + vlen) ? vld : '0;
      @(negedge clk);
      if (k == 1) begin
        clr_at1 = clr_p;
        ovf_at1 = overflow;
      end else begin
        clr_other += $countones(clr_p);
      end
      en_total += $countones(en_p);
      for (int c = 0; c < NC; c++) en_col[c] += int'(en_p[c]);
      if (done_valid) begin
        done_at = k;
        break;
      end
    end
  endtask

  // Holds done_ready low one extra cycle to check stability, then completes the handshake.
  task automatic handshake(input string tag, input logic [7:0] exp_mask);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, " done_hold"}, 32'(done_valid), 32'd1);
    check({tag, " done_mask"}, 32'(done_col_mask), 32'(exp_mask));
    @(posedge clk); #1;
    done_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    done_ready = 1'b0;
    vld_p = '0;
    @(negedge clk);
    check({tag, " idle_ready"}, {30'd0, busy, cmd_ready}, 32'd1);
    check({tag, " done_low"}, 32'(done_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int dcount;
    //           count  mask   vld    start len  en   done ovf
    vecs[0] = '{8'd4,   8'hFF, 8'hFF, 2,    99,  32,  7,   1'b0};
    vecs[1] = '{8'd0,   8'hFF, 8'h00, 2,    99,  0,   4,   1'b0};
    vecs[2] = '{8'd2,   8'h01, 8'h01, 1,    5,   2,   5,   1'b1};
    vecs[3] = '{8'd5,   8'h80, 8'hFF, 2,    5,   5,   8,   1'b0};
    vecs[4] = '{8'd1,   8'h3C, 8'h3C, 2,    3,   4,   4,   1'b0};
    vecs[5] = '{8'd255, 8'h01, 8'h01, 2,    255, 255, 258, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_count = '0; cmd_col_mask = '0; done_ready = 1'b0; vld_p = '0;
    for (int i = 0; i < 16; i++) pat[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset clr_all", 32'(clr_p), 32'hFF);
    check("reset outs", {26'd0, cmd_ready, busy, done_valid, overflow, timeout_err, |en_p}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset ready", 32'(cmd_ready), 32'd1);
    check("post_reset clr", 32'(clr_p), 32'd0);

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      run_job(vecs[v].count, vecs[v].mask, vecs[v].vld, vecs[v].vstart, vecs[v].vlen, 1'b0, tag);
      check({tag, " clear_pulse"}, 32'(clr_at1), 32'(vecs[v].mask));
      check({tag, " stray_clear"}, 32'(clr_other), 32'd0);
      check({tag, " ovf_cleared"}, 32'(ovf_at1), 32'd0);
      check({tag, " enables"}, 32'(en_total), 32'(vecs[v].exp_en));
      check({tag, " done_cycle"}, 32'(done_at), 32'(vecs[v].exp_done));
      check({tag, " overflow"}, 32'(overflow), 32'(vecs[v].exp_ovf));
      check({tag, " timeout_err"}, 32'(timeout_err), 32'd0);
      handshake(tag, vecs[v].mask);
    end

    // Staggered beats: cols 0 and 2 masked, col 5 valid but unmasked.
    pat[2] = 8'h21; pat[3] = 8'h25; pat[4] = 8'h21; pat[5] = 8'h24;
    pat[6] = 8'h20; pat[7] = 8'h24; pat[8] = 8'h20;
    run_job(8'd3, 8'h05, 8'h00, 0, 0, 1'b1, "stagger");
    check("stagger clear_pulse", 32'(clr_at1), 32'h05);
    check("stagger stray_clear", 32'(clr_other), 32'd0);
    check("stagger en_col0", 32'(en_col[0]), 32'd3);
    check("stagger en_col2", 32'(en_col[2]), 32'd3);
    check("stagger en_col5", 32'(en_col[5]), 32'd0);
    check("stagger done_cycle", 32'(done_at), 32'd9);
    check("stagger overflow", 32'(overflow), 32'd0);
    handshake("stagger", 8'h05);

    // Reset for one cycle in the middle of ACCUM.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_count = 8'd4; cmd_col_mask = 8'hFF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    vld_p = 8'hFF;
    @(negedge clk);
    check("midrst pre_en", 32'(en_p), 32'hFF);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst clr_all", 32'(clr_p), 32'hFF);
    check("midrst outs", {28'd0, busy, cmd_ready, done_valid, |en_p}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    vld_p = '0;
    @(negedge clk);
    check("midrst idle", {29'd0, busy, cmd_ready, |clr_p}, 32'd2);
    dcount = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      dcount += int'(done_valid);
    end
    check("midrst no_done", 32'(dcount), 32'd0);

`ifdef ACCUM_CTRL_TIMEOUT_EN
    for (int i = 0; i < 16; i++) pat[i] = '0;
    for (int i = 2; i <= 5; i++) pat[i] = 8'h01;
    run_job(8'd4, 8'h03, 8'h00, 0, 0, 1'b1, "wdog");
    check("wdog done_cycle", 32'(done_at), 32'd22);
    check("wdog timeout_err", 32'(timeout_err), 32'd1);
    check("wdog en_col0", 32'(en_col[0]), 32'd4);
    handshake("wdog", 8'h01);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
